// File: rtl/sched_table_sequencer_if.sv
// rtl/sched_table_sequencer_if.sv - handshake, config and datapath-control bundle
interface sched_table_sequencer_if #(
  parameter int NUM_REGS  = 10,
  parameter int SEL_W     = 4,
  parameter int MAX_STEPS = 16,
  parameter int STEP_W    = 4
);
  localparam int CW_W = NUM_REGS + 5 + 6 * SEL_W;

  logic                start;
  logic                op_ready;
  logic                cfg_we;
  logic [STEP_W-1:0]   cfg_addr;
  logic [CW_W-1:0]     cfg_wdata;
  logic [STEP_W:0]     cfg_len;
  logic                stall;
  logic [SEL_W-1:0]    alu1_sel1, alu1_sel2;
  logic [SEL_W-1:0]    log1_sel1, log1_sel2;
  logic [SEL_W-1:0]    mul1_sel1, mul1_sel2;
  logic                alu1_op;
  logic [1:0]          log1_op;
  logic                mul1_op;
  logic [NUM_REGS-1:0] reg_en;
  logic                result_en;
  logic                done;
  logic [STEP_W-1:0]   step;

  modport master (
    output start, cfg_we, cfg_addr, cfg_wdata, cfg_len, stall,
    input  op_ready, alu1_sel1, alu1_sel2, log1_sel1, log1_sel2, mul1_sel1, mul1_sel2,
           alu1_op, log1_op, mul1_op, reg_en, result_en, done, step
  );

  modport slave (
    input  start, cfg_we, cfg_addr, cfg_wdata, cfg_len, stall,
    output op_ready, alu1_sel1, alu1_sel2, log1_sel1, log1_sel2, mul1_sel1, mul1_sel2,
           alu1_op, log1_op, mul1_op, reg_en, result_en, done, step
  );
endinterface

// File: rtl/sched_table_sequencer.sv
// rtl/sched_table_sequencer.sv - table-driven sequencer for the shared ALU/logic/multiplier datapath
module sched_table_sequencer #(
  parameter int NUM_REGS  = 10,
  parameter int SEL_W     = 4,
  parameter int MAX_STEPS = 16,
  parameter int STEP_W    = 4
) (
  input  logic clk,
  input  logic rst,
  sched_table_sequencer_if.slave seq_if
);
  localparam int CW_W = NUM_REGS + 5 + 6 * SEL_W;
  localparam int B    = NUM_REGS + 5;
  localparam logic [STEP_W:0] MAX_LEN = (STEP_W + 1)'(MAX_STEPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W:0]   len_q;
  logic [STEP_W:0]   len_d;
  logic              op_ready_q;
  logic              done_q;
  logic [CW_W-1:0]   table_q [MAX_STEPS];
  logic [CW_W-1:0]   cw;
  logic              last_step;

  assign len_d     = (seq_if.cfg_len > MAX_LEN) ? MAX_LEN : seq_if.cfg_len;
  assign last_step = ({1'b0, step_q} == (len_q - (STEP_W + 1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      len_q      <= '0;
      op_ready_q <= 1'b1;
      done_q     <= 1'b0;
      for (int i = 0; i < MAX_STEPS; i++) table_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seq_if.cfg_we && ({1'b0, seq_if.cfg_addr} < MAX_LEN))
            table_q[seq_if.cfg_addr] <= seq_if.cfg_wdata;
          if (seq_if.start) begin
            step_q     <= '0;
            len_q      <= len_d;
            op_ready_q <= 1'b0;
            if (seq_if.cfg_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (!seq_if.stall) begin
            if (last_step) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              step_q <= step_q + STEP_W'(1);
            end
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          op_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          op_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Control outputs follow table[step] with no register stage; stall only gates the enables.
  assign cw = (state_q == RUN) ? table_q[step_q] : '0;

  assign seq_if.reg_en    = cw[NUM_REGS-1:0] & {NUM_REGS{~seq_if.stall}};
  assign seq_if.result_en = cw[NUM_REGS] & ~seq_if.stall;
  assign seq_if.mul1_op   = cw[NUM_REGS+1];
  assign seq_if.log1_op   = cw[NUM_REGS+3:NUM_REGS+2];
  assign seq_if.alu1_op   = cw[NUM_REGS+4];
  assign seq_if.mul1_sel2 = cw[B+0*SEL_W +: SEL_W];
  assign seq_if.mul1_sel1 = cw[B+1*SEL_W +: SEL_W];
  assign seq_if.log1_sel2 = cw[B+2*SEL_W +: SEL_W];
  assign seq_if.log1_sel1 = cw[B+3*SEL_W +: SEL_W];
  assign seq_if.alu1_sel2 = cw[B+4*SEL_W +: SEL_W];
  assign seq_if.alu1_sel1 = cw[B+5*SEL_W +: SEL_W];

  assign seq_if.op_ready  = op_ready_q;
  assign seq_if.done      = done_q;
  assign seq_if.step      = step_q;
endmodule

// File: tb/tb_sched_table_sequencer.sv
// tb/tb_sched_table_sequencer.sv - randomized self-checking bench with a pass-level reference model
module tb_sched_table_sequencer;
  localparam int CW_W = 39;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [CW_W-1:0] model_tab [16];

  always #5 clk = ~clk;

  sched_table_sequencer_if bus ();

  sched_table_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW_W-1:0] mk(input int a1, a2, aop, l1, l2, lop, m1, m2, mop, re, ren);
    return {4'(a1), 4'(a2), 4'(l1), 4'(l2), 4'(m1), 4'(m2), 1'(aop), 2'(lop), 1'(mop), 1'(re), 10'(ren)};
  endfunction

  function automatic logic [CW_W-1:0] obs_word();
    return {bus.alu1_sel1, bus.alu1_sel2, bus.log1_sel1, bus.log1_sel2, bus.mul1_sel1, bus.mul1_sel2,
            bus.alu1_op, bus.log1_op, bus.mul1_op, bus.result_en, bus.reg_en};
  endfunction

  function automatic logic [CW_W-1:0] rand_word();
    return {7'($urandom), $urandom};
  endfunction

  task automatic write_entry(input int addr, input logic [CW_W-1:0] data);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'(addr); bus.cfg_wdata = data;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    model_tab[addr] = data;
  endtask

  // Expected behaviour is expressed per pass: entry k is issued on the k-th non-stalled
  // cycle, done follows the last issue, and any config traffic after launch is ignored.
  task automatic run_pass(input int len, input int smode, input bit same_cycle_wr);
    int eff    = (len > 16) ? 16 : len;
    int issued = 0;
    int stalls = 0;
    int cyc    = 0;
    bit s;
    logic [CW_W-1:0] exp;
    @(negedge clk);
    #1;
    check("idle_ready", bus.op_ready, 1);
    check("idle_done", bus.done, 0);
    check("idle_word", obs_word(), 0);
    bus.start = 1'b1; bus.cfg_len = 5'(len); bus.stall = 1'b0;
    if (same_cycle_wr) begin
      int a = $urandom_range(1, 15);
      exp = rand_word();
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'(a); bus.cfg_wdata = exp;
      model_tab[a] = exp;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      bus.start     = 1'($urandom);
      bus.cfg_we    = 1'($urandom);
      bus.cfg_addr  = (issued == 0) ? 4'd2 : 4'($urandom);
      bus.cfg_wdata = rand_word();
      if (issued < eff) begin
        case (smode)
          1:       s = ($urandom_range(0, 3) == 0) && (stalls < 20);
          2:       s = (issued == 3) && (stalls < 3);
          default: s = 1'b0;
        endcase
        bus.stall = s;
        #1;
        exp = model_tab[issued];
        if (s) exp[10:0] = '0;
        check("run_ready", bus.op_ready, 0);
        check("run_done", bus.done, 0);
        check("run_step", bus.step, 64'(issued));
        check("run_word", obs_word(), exp);
        if (s) stalls++; else issued++;
      end else begin
        bus.stall = 1'($urandom);
        #1;
        check("done_pulse", bus.done, 1);
        check("done_word", obs_word(), 0);
        check("latency", 64'(cyc), 64'(eff + stalls + 1));
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.cfg_we = 1'b0; bus.stall = 1'b0;
        break;
      end
      if (cyc > 200) begin
        check("timeout", 1, 0);
        break;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.cfg_len = '0; bus.stall = 1'b0;
    for (int i = 0; i < 16; i++) model_tab[i] = '0;

    #12;
    check("rst_ready", bus.op_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_regen", bus.reg_en, 0);
    check("rst_step", bus.step, 0);
    @(negedge clk);
    rst = 1'b0;

    run_pass(1, 0, 0);

    write_entry(0, mk(1, 2, 0, 2, 0, 1, 2, 1, 1, 0, 'h026));
    write_entry(1, mk(3, 4, 1, 1, 3, 2, 5, 6, 0, 0, 'h001));
    write_entry(2, mk(5, 6, 0, 3, 3, 3, 7, 8, 1, 0, 'h010));
    write_entry(3, mk(4, 5, 1, 6, 7, 0, 9, 10, 0, 0, 'h040));
    write_entry(4, mk(8, 9, 0, 12, 13, 2, 14, 15, 1, 0, 'h180));
    write_entry(5, mk(7, 11, 1, 0, 1, 1, 2, 3, 0, 1, 'h200));
    run_pass(6, 0, 0);
    run_pass(6, 2, 0);
    run_pass(0, 0, 0);

    for (int i = 6; i < 15; i++) write_entry(i, rand_word());
    write_entry(15, rand_word());
    run_pass(16, 0, 0);
    run_pass(20, 0, 0);
    run_pass(6, 0, 1);
    run_pass(6, 1, 0);

    @(negedge clk);
    bus.start = 1'b1; bus.cfg_len = 5'd6;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.stall = 1'b0;
      if (i < 3) @(posedge clk);
    end
    #1;
    check("mid_step", bus.step, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", bus.op_ready, 1);
    check("mid_rst_step", bus.step, 0);
    check("mid_rst_regen", bus.reg_en, 0);
    check("mid_rst_done", bus.done, 0);
    for (int i = 0; i < 16; i++) model_tab[i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_done", bus.done, 0);
    run_pass(1, 0, 0);

    for (int p = 0; p < 30; p++) begin
      int nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) write_entry($urandom_range(0, 15), rand_word());
      run_pass($urandom_range(0, 20), 1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sched_table_sequencer.md
Name: sched_table_sequencer

Overview:
Programmable replacement for the hard-coded per-schedule controller FSMs. It sequences the shared datapath (one ALU, one logic unit, one multiplier, NUM_REGS result registers) from a loadable control-word table. Each table entry is one schedule cycle. Software or a config loader writes the table and length while the block is idle. A start/op_ready/done handshake launches and completes one pass.

Parameters:
NUM_REGS, 10, number of datapath result registers (width of reg_en)
SEL_W, 4, width of each operand-select field
MAX_STEPS, 16, table depth (schedule cycles)
STEP_W, 4, address/length width; must satisfy 2**STEP_W >= MAX_STEPS
CW_W (localparam), NUM_REGS+5+6*SEL_W (=39), control-word width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  launch request, sampled only in IDLE
op_ready  out  1  high in IDLE
cfg_we  in  1  table write strobe
cfg_addr  in  STEP_W  table write address
cfg_wdata  in  CW_W  control word to write
cfg_len  in  STEP_W+1  number of steps to run (0..MAX_STEPS), latched at start
stall  in  1  datapath busy (e.g. multi-cycle multiply); freezes the sequence
alu1_sel1, alu1_sel2, log1_sel1, log1_sel2, mul1_sel1, mul1_sel2  out  SEL_W each  operand selects
alu1_op  out  1  ALU opcode
log1_op  out  2  logic-unit opcode
mul1_op  out  1  multiplier opcode
reg_en  out  NUM_REGS  result-register load enables
result_en  out  1  final result capture enable
done  out  1  one-cycle completion pulse
step  out  STEP_W  current table index (debug/visibility)

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset sets state=IDLE, step=0, latched length=0, and every table entry to all-zero. All outputs then read 0, except op_ready=1.
- Control-word packing, LSB first: reg_en[NUM_REGS-1:0], result_en, mul1_op, log1_op[1:0], alu1_op, mul1_sel2, mul1_sel1, log1_sel2, log1_sel1, alu1_sel2, alu1_sel1 (MSBs).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - op_ready=1; all datapath outputs are 0.
  - cfg_we=1 writes cfg_wdata to entry cfg_addr at the clock edge. Writes with cfg_addr>=MAX_STEPS are dropped.
  - start=1 latches cfg_len and sets step=0.
  - If cfg_len is 0, next state is DONE.
  - If cfg_len exceeds MAX_STEPS, the latched length is clamped to MAX_STEPS; next state is RUN.
  - Otherwise next state is RUN.
- RUN:
  - op_ready=0. All control outputs decode combinationally from table[step], with zero latency from step.
  - stall=0: the word is issued, and step advances at the edge. If step equals latched length minus 1, next state is DONE instead.
  - stall=1: select and opcode fields are still driven from table[step]. reg_en and result_en are forced to 0, and step holds. Every entry's enables are therefore asserted for exactly one non-stalled cycle.
  - start is ignored in RUN.
  - cfg_we is ignored in RUN and DONE; the table is locked while a pass is in flight.
- DONE: done=1 for exactly one cycle, datapath outputs are 0, and next state is IDLE. A start seen in DONE is ignored.
- Back-to-back: start asserted in the first IDLE cycle after DONE launches immediately. The minimum period is length+2 cycles with no stall.
- Total latency from start to done is latched length plus stalled cycles plus 1, with done asserted in the cycle after the last issued step.
- Reset mid-RUN: returns immediately to IDLE, no done is emitted, and the table is cleared.
- A cfg_we in the same cycle as start is honoured. The written entry is visible to the pass only if its address is later than step 0, because step 0 is read in the first RUN cycle, after the write completes.

Test Plan:
- Reset then idle: assert rst mid-cycle -> op_ready=1, done=0, reg_en=0, step=0. Read-back through a 1-step run gives all-zero outputs.
- Six-step schedule: load entries 0..5, cfg_len=6, pulse start. Expect one entry per cycle in RUN cycles 1..6:
  - entry 0: alu sel 1/2 op0, log sel 2/0 op 01, mul sel 2/1 op1, reg_en=0x026.
  - entry 5: alu sel 7/11, reg_en bit9, result_en=1.
  - done=1 in cycle 7, op_ready=1 in cycle 8.
- Stall: same program with stall=1 for 3 cycles during step 3. Expect step held at 3, reg_en=0 for those cycles, selects still 4/5, and done delayed by exactly 3 cycles.
- Boundaries:
  - cfg_len=0 -> done on the cycle after start, no enables asserted.
  - cfg_len=16 -> runs 16 steps, step wraps to 0 only via IDLE.
  - cfg_len=20 -> clamped to 16.
- Config lock: cfg_we to entry 2 during RUN -> entry 2 unchanged, verified on the next pass. A write with cfg_addr=15 in IDLE is visible.
- Reset mid-run: rst at step 3 -> immediate IDLE, no done pulse. A subsequent start with cfg_len=1 yields all-zero outputs and done 2 cycles after start.
